// File: rtl/nor_gate_array.sv
// nor_gate_array: CHANNELS independent masked FANIN-input NOR gates with a two-phase
// delay model (negedge sample, posedge commit), step/hold enable and toggle debug.
module nor_gate_array #(
   parameter int                  CHANNELS     = 8,
   parameter int                  FANIN        = 4,
   parameter int                  DELAY_CYCLES = 1,
   parameter logic [CHANNELS-1:0] IV           = {CHANNELS{1'b0}},
   parameter int                  CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [CHANNELS*FANIN-1:0] a,
   input  logic [CHANNELS*FANIN-1:0] mask,
   input  logic                      cnt_clr,
   output logic [CHANNELS-1:0]       y,
   output logic [CHANNELS-1:0]       changed,
   output logic [CNT_W-1:0]          toggle_cnt
);

   localparam int INC_W = $clog2(CHANNELS + 1);
   localparam int SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;

   generate
      if (FANIN < 1 || FANIN > 16) begin : g_bad_fanin
         $error("nor_gate_array: FANIN must be in 1..16");
      end
      if (DELAY_CYCLES < 1 || DELAY_CYCLES > 8) begin : g_bad_delay
         $error("nor_gate_array: DELAY_CYCLES must be in 1..8");
      end
   endgenerate

   function automatic logic [INC_W-1:0] popcount(input logic [CHANNELS-1:0] v);
      logic [INC_W-1:0] n;
      n = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         n = n + INC_W'(v[i]);
      end
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [INC_W-1:0] inc);
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] lim;
      sum = SUM_W'(cnt) + SUM_W'(inc);
      lim = SUM_W'({CNT_W{1'b1}});
      if (sum > lim) begin
         return {CNT_W{1'b1}};
      end
      return sum[CNT_W-1:0];
   endfunction

   // Combinational evaluation: masked inputs are forced low, so a fully masked gate reads 1.
   logic [CHANNELS-1:0] nv;

   always_comb begin
      nv = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         nv[c] = ~|(a[c*FANIN +: FANIN] & ~mask[c*FANIN +: FANIN]);
      end
   end

   // Stage p0: falling-edge sample register.
   logic [CHANNELS-1:0] smp_p0;

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         smp_p0 <= IV;
      end else if (en) begin
         smp_p0 <= nv;
      end
   end

   // Stage p1: rising-edge commit chain; the last entry drives y.
   logic [CHANNELS-1:0] stage_p1 [DELAY_CYCLES];
   logic [CHANNELS-1:0] y_next;
   logic [CHANNELS-1:0] toggles;

   generate
      if (DELAY_CYCLES == 1) begin : g_d1
         assign y_next = smp_p0;
      end else begin : g_dn
         assign y_next = stage_p1[DELAY_CYCLES-2];
      end
   endgenerate

   assign y       = stage_p1[DELAY_CYCLES-1];
   assign toggles = y_next ^ y;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DELAY_CYCLES; k++) begin
            stage_p1[k] <= IV;
         end
         changed    <= '0;
         toggle_cnt <= '0;
      end else begin
         if (en) begin
            stage_p1[0] <= smp_p0;
            for (int k = 1; k < DELAY_CYCLES; k++) begin
               stage_p1[k] <= stage_p1[k-1];
            end
            changed <= toggles;
         end else begin
            changed <= '0;
         end
         // Clear wins over the same-edge increment.
         if (cnt_clr) begin
            toggle_cnt <= '0;
         end else if (en) begin
            toggle_cnt <= sat_add(toggle_cnt, popcount(toggles));
         end
      end
   end

endmodule
